ad7908_spi_responder: RTL and testbench

- Synthesizable SPI peripheral that emulates the AD7908 8-channel 8-bit ADC on the FPGA side of the bus.
- Samples the master's SCK, CS_N and MOSI with the system clock, decodes the 12-bit control word, and returns conversion frames on MISO built from a parallel channel-value bus.
- Used as an on-chip stand-in for the ADC during bring-up and in closed-loop benches of the ADC controller.

---
 rtl/ad7908_spi_responder_if.sv | 25 ++
 rtl/ad7908_spi_responder.sv | 181 ++++++++++++++++++
 tb/tb_ad7908_spi_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ad7908_spi_responder_if.sv
// SPI pin bundle between an AD7908-style ADC master and the FPGA-side responder.
// The master modport drives SCK/CS_N/MOSI. The slave modport returns MISO and its output enable.
interface ad7908_spi_responder_if;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sck,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sck,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/ad7908_spi_responder.sv
// AD7908 emulator: an 8-channel 8-bit ADC seen from the SPI bus.
// SCK, CS_N and MOSI are oversampled by clk through SYNC_STAGES-deep synchronizers (legal 2..4).
// Each frame returns {0, addr[2:0], data[7:0], 0000} on MISO. A WRITE control word selects the
// address that is converted in the following frame.
// Optional feature macro: AD7908_RESP_STATS_EN adds the frame_cnt/err_cnt statistics outputs.
module ad7908_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [2:0]  RESET_ADDR  = 3'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    ad7908_spi_responder_if.slave spi,
    input  logic [63:0]           ch_data,
    output logic [11:0]           ctrl_word,
    output logic [2:0]            cur_addr,
    output logic                  frame_done,
    output logic                  frame_err
`ifdef AD7908_RESP_STATS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            err_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_END} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   sck_prev_reg;
    logic                   cs_prev_reg;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    state_t      state_reg;
    logic [15:0] tx_shift_reg;
    logic [11:0] rx_shift_reg;
    logic [4:0]  rise_cnt_reg;
    logic        oe_reg;
    logic [11:0] ctrl_word_reg;
    logic [2:0]  cur_addr_reg;
    logic        frame_done_reg;
    logic        frame_err_reg;

    logic [7:0]  ch_val [8];
    logic [7:0]  sel_val;
    logic [7:0]  tx_data;

    // Synchronizers. CS_N clears to 0, so a CS_N that is already low when reset releases
    // never looks like a falling edge: a frame can start only after CS_N is seen high first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_reg  <= '0;
            cs_sync_reg   <= '0;
            mosi_sync_reg <= '0;
            sck_prev_reg  <= 1'b0;
            cs_prev_reg   <= 1'b0;
        end else begin
            sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi.spi_sck};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi.spi_cs_n};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi.spi_mosi};
            sck_prev_reg  <= sck_s;
            cs_prev_reg   <= cs_s;
        end
    end

    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;
    assign cs_fall  = ~cs_s & cs_prev_reg;
    assign cs_rise  = cs_s & ~cs_prev_reg;

    // Split the flat channel bus into per-channel bytes.
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        assign ch_val[gi] = ch_data[8*gi +: 8];
    end

    // Track/hold sample of the addressed channel. CODING=0 selects two's complement (MSB flipped).
    always_comb begin
        sel_val = ch_val[cur_addr_reg];
        tx_data = ctrl_word_reg[0] ? sel_val : (sel_val ^ 8'h80);
    end

    // Frame FSM: load on CS fall, shift MOSI on SCK rise and MISO on SCK fall, decode on CS rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tx_shift_reg   <= '0;
            rx_shift_reg   <= '0;
            rise_cnt_reg   <= '0;
            oe_reg         <= 1'b0;
            ctrl_word_reg  <= 12'h000;
            cur_addr_reg   <= RESET_ADDR;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_reg    <= ST_SHIFT;
                        tx_shift_reg <= {1'b0, cur_addr_reg, tx_data, 4'b0000};
                        rx_shift_reg <= '0;
                        rise_cnt_reg <= '0;
                        oe_reg       <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // CS rise takes priority over a coincident SCK fall.
                    if (cs_rise) begin
                        state_reg <= ST_END;
                        oe_reg    <= 1'b0;
                    end else begin
                        if (sck_rise) begin
                            // Only the first 12 MOSI bits form the control word.
                            if (rise_cnt_reg < 5'd12) begin
                                rx_shift_reg <= {rx_shift_reg[10:0], mosi_s};
                            end
                            if (rise_cnt_reg != 5'd31) begin
                                rise_cnt_reg <= rise_cnt_reg + 5'd1;
                            end
                        end
                        // Zero fill keeps MISO low once all 16 bits have been sent.
                        if (sck_fall && (rise_cnt_reg != 5'd0)) begin
                            tx_shift_reg <= {tx_shift_reg[14:0], 1'b0};
                        end
                    end
                end
                ST_END: begin
                    state_reg    <= ST_IDLE;
                    tx_shift_reg <= '0;
                    if (rise_cnt_reg >= 5'd16) begin
                        frame_done_reg <= 1'b1;
                        if (rx_shift_reg[11]) begin
                            ctrl_word_reg <= rx_shift_reg;
                            cur_addr_reg  <= rx_shift_reg[8:6];
                        end
                    end else begin
                        frame_err_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign spi.spi_miso    = tx_shift_reg[15];
    assign spi.spi_miso_oe = oe_reg;
    assign ctrl_word       = ctrl_word_reg;
    assign cur_addr        = cur_addr_reg;
    assign frame_done      = frame_done_reg;
    assign frame_err       = frame_err_reg;

`ifdef AD7908_RESP_STATS_EN
    logic [15:0] frame_cnt_reg;
    logic [7:0]  err_cnt_reg;

    // Saturating counters of good and short frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else begin
            if (frame_done_reg && (frame_cnt_reg != 16'hFFFF)) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (frame_err_reg && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_reg;
    assign err_cnt   = err_cnt_reg;
`endif

endmodule

// File: tb/tb_ad7908_spi_responder.sv
// Directed testbench for ad7908_spi_responder: a bit-banged SPI master with hand-computed frames.
module tb_ad7908_spi_responder;
    localparam int HALF = 8;   // SCK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ch_data;
    logic [11:0] ctrl_word;
    logic [2:0]  cur_addr;
    logic        frame_done;
    logic        frame_err;
`ifdef AD7908_RESP_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int done_seen = 0;
    int err_seen  = 0;

    ad7908_spi_responder_if spi_if ();

    ad7908_spi_responder #(.SYNC_STAGES(2), .RESET_ADDR(3'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi_if),
        .ch_data    (ch_data),
        .ctrl_word  (ctrl_word),
        .cur_addr   (cur_addr),
        .frame_done (frame_done),
        .frame_err  (frame_err)
`ifdef AD7908_RESP_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #10 clk = ~clk;

    // Count pulse cycles so that a stretched pulse also shows up as a wrong count.
    always @(negedge clk) begin
        if (frame_done) done_seen++;
        if (frame_err)  err_seen++;
    end

    // One SPI frame. MOSI is sent MSB first, and bits past 16 are driven as 1.
    // MISO is sampled at every SCK rise.
    task automatic spi_frame(input logic [15:0] tx, input int nbits, input bit raise_cs,
                             output logic [31:0] rx);
        rx = '0;
        spi_if.spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_if.spi_mosi = (i < 16) ? tx[15-i] : 1'b1;
            repeat (HALF) @(negedge clk);
            spi_if.spi_sck = 1'b1;
            rx = {rx[30:0], spi_if.spi_miso};
            repeat (HALF) @(negedge clk);
            spi_if.spi_sck = 1'b0;
        end
        if (raise_cs) begin
            repeat (HALF) @(negedge clk);
            spi_if.spi_cs_n = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spi_if.spi_cs_n = 1'b1;
        spi_if.spi_sck  = 1'b0;
        spi_if.spi_mosi = 1'b0;
        ch_data = '0;
        repeat (5) @(negedge clk);
        chk_cnt++; if (spi_if.spi_miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", spi_if.spi_miso); else pass_cnt++;
        chk_cnt++; if (spi_if.spi_miso_oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", spi_if.spi_miso_oe); else pass_cnt++;
        chk_cnt++; if (ctrl_word !== 12'h000) $display("FAIL reset_ctrl: got %h expected 000", ctrl_word); else pass_cnt++;
        chk_cnt++; if (cur_addr !== 3'd0) $display("FAIL reset_addr: got %0d expected 0", cur_addr); else pass_cnt++;
        chk_cnt++; if ({frame_done, frame_err} !== 2'b00) $display("FAIL reset_pulses: got %b expected 00", {frame_done, frame_err}); else pass_cnt++;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        $display("reset: ctrl_word=%h cur_addr=%0d", ctrl_word, cur_addr);
    endtask

    task automatic test_basic_frame();
        logic [31:0] rx;
        int d0, e0;
        ch_data[7:0] = 8'h5A;
        d0 = done_seen; e0 = err_seen;
        spi_frame(16'h8330, 16, 1'b1, rx);   // cw 100_000_110011, WRITE, ch0, binary coding
        $display("frame cw=833: miso=%h", rx[15:0]);
        chk_cnt++; if (rx[15:0] !== 16'h0DA0) $display("FAIL basic_miso: got %h expected 0DA0", rx[15:0]); else pass_cnt++;
        chk_cnt++; if (done_seen - d0 !== 1) $display("FAIL basic_done: got %0d pulses expected 1", done_seen - d0); else pass_cnt++;
        chk_cnt++; if (err_seen - e0 !== 0) $display("FAIL basic_err: got %0d pulses expected 0", err_seen - e0); else pass_cnt++;
        chk_cnt++; if (ctrl_word !== 12'h833) $display("FAIL basic_ctrl: got %h expected 833", ctrl_word); else pass_cnt++;
        chk_cnt++; if (cur_addr !== 3'd0) $display("FAIL basic_addr: got %0d expected 0", cur_addr); else pass_cnt++;
    endtask

    task automatic test_addr_pipeline();
        logic [31:0] rx;
        ch_data[7:0]  = 8'hFF;
        ch_data[15:8] = 8'h3C;
        spi_frame(16'h8730, 16, 1'b1, rx);   // WRITE, ch1, binary
        $display("frame cw=873: miso=%h", rx[15:0]);
        chk_cnt++; if (rx[15:0] !== 16'h0FF0) $display("FAIL pipe_first: got %h expected 0FF0", rx[15:0]); else pass_cnt++;
        chk_cnt++; if (cur_addr !== 3'd1) $display("FAIL pipe_addr: got %0d expected 1", cur_addr); else pass_cnt++;
        spi_frame(16'h8730, 16, 1'b1, rx);
        $display("frame cw=873: miso=%h", rx[15:0]);
        chk_cnt++; if (rx[15:0] !== 16'h13C0) $display("FAIL pipe_second: got %h expected 13C0", rx[15:0]); else pass_cnt++;
        chk_cnt++; if (ctrl_word !== 12'h873) $display("FAIL pipe_ctrl: got %h expected 873", ctrl_word); else pass_cnt++;
    endtask

    task automatic test_read_only();
        logic [31:0] rx;
        spi_frame(16'h1400, 16, 1'b1, rx);   // WRITE=0, ADD=101
        $display("frame cw=140: miso=%h", rx[15:0]);
        chk_cnt++; if (rx[15:0] !== 16'h13C0) $display("FAIL ro_miso: got %h expected 13C0", rx[15:0]); else pass_cnt++;
        chk_cnt++; if (ctrl_word !== 12'h873) $display("FAIL ro_ctrl: got %h expected 873", ctrl_word); else pass_cnt++;
        chk_cnt++; if (cur_addr !== 3'd1) $display("FAIL ro_addr: got %0d expected 1", cur_addr); else pass_cnt++;
        spi_frame(16'h8730, 16, 1'b1, rx);
        $display("frame cw=873: miso=%h", rx[15:0]);
        chk_cnt++; if (rx[14:12] !== 3'd1) $display("FAIL ro_next_addr_field: got %0d expected 1", rx[14:12]); else pass_cnt++;
    endtask

    task automatic test_short_frame();
        logic [31:0] rx;
        int d0, e0;
        d0 = done_seen; e0 = err_seen;
        spi_frame(16'h8800, 9, 1'b1, rx);
        $display("short frame 9 bits: frame_err pulses=%0d", err_seen - e0);
        chk_cnt++; if (err_seen - e0 !== 1) $display("FAIL short_err: got %0d pulses expected 1", err_seen - e0); else pass_cnt++;
        chk_cnt++; if (done_seen - d0 !== 0) $display("FAIL short_done: got %0d pulses expected 0", done_seen - d0); else pass_cnt++;
        chk_cnt++; if (ctrl_word !== 12'h873) $display("FAIL short_ctrl: got %h expected 873", ctrl_word); else pass_cnt++;
        chk_cnt++; if (cur_addr !== 3'd1) $display("FAIL short_addr: got %0d expected 1", cur_addr); else pass_cnt++;
        ch_data[23:16] = 8'h01;
        spi_frame(16'h8800, 16, 1'b1, rx);   // WRITE, ch2, two's complement
        $display("frame cw=880: miso=%h", rx[15:0]);
        chk_cnt++; if (rx[15:0] !== 16'h13C0) $display("FAIL after_short_miso: got %h expected 13C0", rx[15:0]); else pass_cnt++;
        spi_frame(16'h8800, 16, 1'b1, rx);
        $display("frame cw=880: miso=%h", rx[15:0]);
        chk_cnt++; if (rx[15:0] !== 16'h2810) $display("FAIL twos_ch2_miso: got %h expected 2810", rx[15:0]); else pass_cnt++;
    endtask

    task automatic test_long_frame();
        logic [31:0] rx;
        int d0;
        d0 = done_seen;
        spi_frame(16'h8800, 20, 1'b1, rx);
        $display("long frame 20 bits: miso=%h", rx[19:0]);
        chk_cnt++; if (rx[19:4] !== 16'h2810) $display("FAIL long_miso: got %h expected 2810", rx[19:4]); else pass_cnt++;
        chk_cnt++; if (rx[3:0] !== 4'h0) $display("FAIL long_tail: got %h expected 0", rx[3:0]); else pass_cnt++;
        chk_cnt++; if (done_seen - d0 !== 1) $display("FAIL long_done: got %0d pulses expected 1", done_seen - d0); else pass_cnt++;
        chk_cnt++; if (ctrl_word !== 12'h880) $display("FAIL long_ctrl: got %h expected 880", ctrl_word); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rx;
        int d0, e0;
        ch_data[7:0] = 8'h5A;
        spi_frame(16'h8800, 5, 1'b0, rx);    // CS_N stays low
        chk_cnt++; if (spi_if.spi_miso_oe !== 1'b1) $display("FAIL mid_oe: got %b expected 1", spi_if.spi_miso_oe); else pass_cnt++;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_cnt++; if (spi_if.spi_miso !== 1'b0) $display("FAIL rstmid_miso: got %b expected 0", spi_if.spi_miso); else pass_cnt++;
        chk_cnt++; if (spi_if.spi_miso_oe !== 1'b0) $display("FAIL rstmid_oe: got %b expected 0", spi_if.spi_miso_oe); else pass_cnt++;
        chk_cnt++; if (ctrl_word !== 12'h000) $display("FAIL rstmid_ctrl: got %h expected 000", ctrl_word); else pass_cnt++;
        chk_cnt++; if (cur_addr !== 3'd0) $display("FAIL rstmid_addr: got %0d expected 0", cur_addr); else pass_cnt++;
        d0 = done_seen; e0 = err_seen;
        spi_if.spi_cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
        $display("reset mid-frame, CS_N raised: done=%0d err=%0d", done_seen - d0, err_seen - e0);
        chk_cnt++; if ((done_seen - d0) + (err_seen - e0) !== 0) $display("FAIL rstmid_pulses: got %0d expected 0", (done_seen - d0) + (err_seen - e0)); else pass_cnt++;
        spi_frame(16'h0000, 16, 1'b1, rx);
        $display("frame cw=000: miso=%h", rx[15:0]);
        chk_cnt++; if (rx[15:0] !== 16'h0DA0) $display("FAIL rstmid_next: got %h expected 0DA0", rx[15:0]); else pass_cnt++;
    endtask

`ifdef AD7908_RESP_STATS_EN
    task automatic test_stats();
        logic [31:0] rx;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) spi_frame(16'h8330, 16, 1'b1, rx);
        for (int i = 0; i < 2; i++) spi_frame(16'h8330, 7, 1'b1, rx);
        $display("stats: frame_cnt=%0d err_cnt=%0d", frame_cnt, err_cnt);
        chk_cnt++; if (frame_cnt !== 16'd3) $display("FAIL stats_frames: got %0d expected 3", frame_cnt); else pass_cnt++;
        chk_cnt++; if (err_cnt !== 8'd2) $display("FAIL stats_errs: got %0d expected 2", err_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_addr_pipeline();
        test_read_only();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
`ifdef AD7908_RESP_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
